scenario_state_logger: RTL

//   Downstream consumer of the self-test FSM's out.scenario_state word.

---
 rtl/scenario_state_logger_if.sv | 12 +
 rtl/scenario_state_logger.sv | 96 +++++++++
 2 files changed

// File: rtl/scenario_state_logger_if.sv
// Record stream between the scenario-state logger and its readout consumer.
// Carries the FIFO head record and the valid/ready handshake.
interface scenario_state_logger_if #(
    parameter int DATA_W = 40
) ();
    logic              rec_valid;
    logic [DATA_W-1:0] rec_data;
    logic              rec_ready;

    modport master (output rec_valid, output rec_data, input rec_ready);
    modport slave  (input rec_valid, input rec_data, output rec_ready);
endinterface

// File: rtl/scenario_state_logger.sv
// Timestamps every change of the monitored scenario_state word and queues
// {timestamp, state} records in a first-word-fall-through FIFO for readout.
module scenario_state_logger #(
    parameter int STATE_W = 8,
    parameter int TS_W    = 32,
    parameter int DEPTH   = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [STATE_W-1:0]       scenario_state,
    scenario_state_logger_if.master  rec,
    output logic [$clog2(DEPTH):0]   level,
    output logic [15:0]              drop_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int REC_W = TS_W + STATE_W;

    logic [TS_W-1:0]    ts_q, ts_d;
    logic [STATE_W-1:0] prev_state_q, prev_state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic [15:0]        drop_count_q, drop_count_d;
    logic [REC_W-1:0]   mem_q [DEPTH];
    logic [REC_W-1:0]   mem_d [DEPTH];

    logic push, pop, accept, full, head_valid;

    // Valid depends only on registered level, so rec_ready never reaches rec_valid combinationally.
    assign head_valid = (level_q != '0);
    assign full       = (level_q == LVL_W'(DEPTH));
    assign push       = enable && (scenario_state != prev_state_q);
    assign pop        = head_valid && rec.rec_ready;
    // When full, a same-cycle pop frees the slot the write lands in.
    assign accept     = push && (!full || pop);

    assign rec.rec_valid = head_valid;
    assign rec.rec_data  = head_valid ? mem_q[rd_ptr_q] : '0;
    assign level         = level_q;
    assign drop_count    = drop_count_q;

    always_comb begin
        ts_d         = ts_q;
        prev_state_d = scenario_state;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        drop_count_d = drop_count_q;
        mem_d        = mem_q;

        if (enable) begin
            ts_d = ts_q + TS_W'(1);
        end

        if (accept) begin
            mem_d[wr_ptr_q] = {ts_q, scenario_state};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end else if (push && drop_count_q != 16'hFFFF) begin
            drop_count_d = drop_count_q + 16'd1;
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        if (accept && !pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (pop && !accept) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ts_q         <= '0;
            prev_state_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            drop_count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            ts_q         <= ts_d;
            prev_state_q <= prev_state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            drop_count_q <= drop_count_d;
            mem_q        <= mem_d;
        end
    end
endmodule
